irq_aggregator: RTL

- Avalon-MM slave that collects interrupt lines from the interval timer and other peripherals into one registered interrupt output for the Nios CPU.
- Detects events per source, in edge or level mode, and latches them in a pending register with mask, write-1-to-clear and overrun flags.
- Provides a 32-bit saturating event counter on one selectable source so firmware can detect missed timer ticks.
- Sits directly downstream of the timer irq; software reads it over the same 16-bit register bus used by the timer.

---
 rtl/irq_aggregator.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/irq_aggregator.sv
`default_nettype none
// ============================================================================
//  Module      : irq_aggregator
//  Description : Collects per-source interrupt events (edge or level) into a
//                masked pending register with overrun flags, a registered
//                aggregate irq and a snapshot-readable 32-bit event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_aggregator #(
    parameter int NUM_SRC = 4,
    parameter bit CNT_SAT = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic               read,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq
);

    localparam logic [2:0] c_ADDR_PENDING = 3'd0;
    localparam logic [2:0] c_ADDR_MASK    = 3'd1;
    localparam logic [2:0] c_ADDR_MODE    = 3'd2;
    localparam logic [2:0] c_ADDR_OVERRUN = 3'd3;
    localparam logic [2:0] c_ADDR_CNT_SEL = 3'd4;
    localparam logic [2:0] c_ADDR_CONTROL = 3'd5;
    localparam logic [2:0] c_ADDR_CNT_LO  = 3'd6;
    localparam logic [2:0] c_ADDR_CNT_HI  = 3'd7;

    logic [NUM_SRC-1:0] r_src_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] r_overrun;
    logic [3:0]         r_cnt_sel;
    logic               r_enable;
    logic [31:0]        r_count;
    logic [15:0]        r_cnt_hold;

    logic               w_wr;
    logic               w_rd;
    logic [NUM_SRC-1:0] w_event;
    logic [NUM_SRC-1:0] w_pend_clr;
    logic [NUM_SRC-1:0] w_ovr_clr;
    logic [NUM_SRC-1:0] w_ovr_set;
    logic               w_sel_event;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic [15:0]        w_rdata;
    logic               w_unused_ok;

    assign w_wr = chipselect & ~write_n;
    assign w_rd = chipselect & read;

    // Edge mode masks the source with its delayed copy; level mode passes it through.
    assign w_event    = irq_src & ~(r_src_d & r_mode);
    assign w_pend_clr = (w_wr && address == c_ADDR_PENDING) ? writedata[NUM_SRC-1:0] : '0;
    assign w_ovr_clr  = (w_wr && address == c_ADDR_OVERRUN) ? writedata[NUM_SRC-1:0] : '0;
    assign w_ovr_set  = w_event & r_mode & r_pending & ~w_pend_clr;
    assign w_cnt_clr  = w_wr && address == c_ADDR_CONTROL && writedata[1];
    assign w_cnt_inc  = w_sel_event && !(CNT_SAT && (&r_count));

    assign w_unused_ok = ^writedata;

    always_comb begin
        w_sel_event = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_cnt_sel == 4'(i)) begin
                w_sel_event = w_event[i];
            end
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        case (address)
            c_ADDR_PENDING: w_rdata = 16'(r_pending);
            c_ADDR_MASK:    w_rdata = 16'(r_mask);
            c_ADDR_MODE:    w_rdata = 16'(r_mode);
            c_ADDR_OVERRUN: w_rdata = 16'(r_overrun);
            c_ADDR_CNT_SEL: w_rdata = {12'h000, r_cnt_sel};
            c_ADDR_CONTROL: w_rdata = {15'h0000, r_enable};
            c_ADDR_CNT_LO:  w_rdata = r_count[15:0];
            c_ADDR_CNT_HI:  w_rdata = r_cnt_hold;
            default:        w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_d   <= '0;
            r_pending <= '0;
            r_overrun <= '0;
            irq       <= 1'b0;
            readdata  <= 16'h0000;
        end else begin
            r_src_d   <= irq_src;
            r_pending <= (r_pending & ~w_pend_clr) | w_event;
            r_overrun <= (r_overrun & ~w_ovr_clr) | w_ovr_set;
            irq       <= r_enable & (|(r_pending & r_mask));
            readdata  <= w_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask    <= '0;
            r_mode    <= '1;
            r_cnt_sel <= 4'h0;
            r_enable  <= 1'b0;
        end else if (w_wr) begin
            if (address == c_ADDR_MASK)    r_mask    <= writedata[NUM_SRC-1:0];
            if (address == c_ADDR_MODE)    r_mode    <= writedata[NUM_SRC-1:0];
            if (address == c_ADDR_CNT_SEL) r_cnt_sel <= writedata[3:0];
            if (address == c_ADDR_CONTROL) r_enable  <= writedata[0];
        end
    end

    // Clear strobe beats a same-cycle increment and snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= 32'h0000_0000;
            r_cnt_hold <= 16'h0000;
        end else begin
            if (w_cnt_clr) begin
                r_count <= 32'h0000_0000;
            end else if (w_cnt_inc) begin
                r_count <= r_count + 32'd1;
            end
            if (w_cnt_clr) begin
                r_cnt_hold <= 16'h0000;
            end else if (w_rd && address == c_ADDR_CNT_LO) begin
                r_cnt_hold <= r_count[31:16];
            end
        end
    end

endmodule
`default_nettype wire
